fpga_tx_control_mc: RTL and testbench



---
 rtl/fpga_tx_control_mc_pkg.sv | 31 +++
 rtl/fpga_tx_control_mc_sel_sync.sv | 26 ++
 rtl/fpga_tx_control_mc.sv | 228 ++++++++++++++++++++++
 tb/tb_fpga_tx_control_mc.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_tx_control_mc_pkg.sv
// Shared types and constants for the multi-channel FIFO-A -> interface -> FIFO-B sequencer.
package fpga_tx_control_mc_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_FETCH_WAIT,
    S_DECODE,
    S_TRIG_W,
    S_WAIT_W,
    S_TRIG_R,
    S_WAIT_R,
    S_CAPTURE,
    S_PUSH,
    S_BEAT_DONE,
    S_DFETCH,
    S_DFETCH_WAIT,
    S_DDECODE
  } state_t;

  localparam int unsigned SEL_W        = 4;
  localparam int unsigned ERR_CNT_W    = 16;
  localparam int unsigned RESP_ERR_BIT = 31;
  localparam int unsigned RESP_CH_LSB  = 24;

  // Saturating increment for the timeout error counter.
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fpga_tx_control_mc_sel_sync.sv
// Multi-stage synchroniser for the asynchronous channel-select WireIn.
module fpga_tx_control_mc_sel_sync #(
  parameter int unsigned STAGES = 3,
  parameter int unsigned WIDTH  = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_sync [STAGES];

  // Shift the select through the synchroniser chain.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= i_d;
      for (int unsigned i = 1; i < STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/fpga_tx_control_mc.sv
// Burst-capable command sequencer: pops commands from FIFO A, drives one of
// N_ITF interface masters, returns read data / timeout status to FIFO B.
module fpga_tx_control_mc
  import fpga_tx_control_mc_pkg::*;
#(
  parameter int unsigned N_ITF       = 4,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned BURST_W     = 8,
  parameter int unsigned TIMEOUT_CYC = 65535,
  parameter int unsigned SEL_SYNC    = 3
) (
  input  logic                      CLK,
  input  logic                      rst,
  input  logic [31:0]               FIFOA_OUT,
  output logic                      FIFOA_ren,
  input  logic                      FIFOA_empty,
  output logic [31:0]               FIFOB_IN,
  output logic                      FIFOB_wen,
  input  logic                      FIFOB_full,
  input  logic [SEL_W-1:0]          itf_sel,
  output logic [SEL_W-1:0]          itf_sel_sync,
  output logic [ADDR_W-1:0]         addr_byte,
  output logic [DATA_W-1:0]         data_byte,
  output logic [N_ITF-1:0]          WriteByteStart,
  output logic [N_ITF-1:0]          ReadByteStart,
  input  logic [N_ITF-1:0]          itf_w_finish,
  input  logic [N_ITF-1:0]          itf_rd_valid,
  input  logic [N_ITF*DATA_W-1:0]   itf_rd_data,
  output logic                      busy,
  output logic [ERR_CNT_W-1:0]      err_cnt
);

  localparam int unsigned F_ADDR = DATA_W;
  localparam int unsigned F_WR   = DATA_W + ADDR_W;
  localparam int unsigned F_INC  = F_WR + 1;
  localparam int unsigned F_LEN  = F_WR + 2;
  localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TCNT_W-1:0] TLIM = TCNT_W'(TIMEOUT_CYC - 1);

  if (DATA_W + ADDR_W + 2 + BURST_W > 32 || DATA_W + ADDR_W + 5 > 32) begin : g_bad_fields
    $error("command/response fields do not fit in 32 bits");
  end
  if (N_ITF < 1 || N_ITF > 16 || SEL_SYNC < 2 || TIMEOUT_CYC < 1) begin : g_bad_params
    $error("illegal N_ITF, SEL_SYNC or TIMEOUT_CYC");
  end

  state_t               r_state, w_state_nxt;
  logic [SEL_W-1:0]     r_ch;
  logic [ADDR_W-1:0]    r_addr;
  logic [DATA_W-1:0]    r_data;
  logic [DATA_W-1:0]    r_rdata;
  logic                 r_wr, r_inc, r_err, r_abort;
  logic [BURST_W-1:0]   r_len, r_beat;
  logic [TCNT_W-1:0]    r_tcnt;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  logic [N_ITF-1:0]     w_onehot;
  logic                 w_fin, w_vld, w_tout, w_bad_ch, w_last;
  logic [DATA_W-1:0]    w_rd;
  logic                 w_unused_fifoa;

  fpga_tx_control_mc_sel_sync #(.STAGES(SEL_SYNC), .WIDTH(SEL_W)) u_sel_sync (
    .i_clk (CLK),
    .i_rst (rst),
    .i_d   (itf_sel),
    .o_q   (itf_sel_sync)
  );

  assign w_onehot       = N_ITF'(1) << r_ch;
  assign w_fin          = |(itf_w_finish & w_onehot);
  assign w_vld          = |(itf_rd_valid & w_onehot);
  assign w_tout         = (r_tcnt >= TLIM);
  assign w_bad_ch       = ({1'b0, itf_sel_sync} >= 5'(N_ITF));
  assign w_last         = (r_beat == r_len);
  assign w_unused_fifoa = ^FIFOA_OUT;

  // Select the read data lane of the active channel.
  always_comb begin
    w_rd = '0;
    for (int unsigned k = 0; k < N_ITF; k++) begin
      if (r_ch == 4'(k)) w_rd = itf_rd_data[k*DATA_W +: DATA_W];
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and strobe decode; finish/valid take priority over timeout expiry.
  always_comb begin
    w_state_nxt    = r_state;
    FIFOA_ren      = 1'b0;
    FIFOB_wen      = 1'b0;
    WriteByteStart = '0;
    ReadByteStart  = '0;
    case (r_state)
      S_IDLE:        if (!FIFOA_empty) w_state_nxt = S_FETCH;
      S_FETCH: begin
        FIFOA_ren   = 1'b1;
        w_state_nxt = S_FETCH_WAIT;
      end
      S_FETCH_WAIT:  w_state_nxt = S_DECODE;
      S_DECODE: begin
        if (w_bad_ch)              w_state_nxt = S_PUSH;
        else if (FIFOA_OUT[F_WR])  w_state_nxt = S_TRIG_W;
        else                       w_state_nxt = S_TRIG_R;
      end
      S_TRIG_W: begin
        WriteByteStart = w_onehot;
        w_state_nxt    = S_WAIT_W;
      end
      S_WAIT_W: begin
        if (w_fin)       w_state_nxt = S_BEAT_DONE;
        else if (w_tout) w_state_nxt = S_PUSH;
      end
      S_TRIG_R: begin
        ReadByteStart = w_onehot;
        w_state_nxt   = S_WAIT_R;
      end
      S_WAIT_R: begin
        if (w_vld)       w_state_nxt = S_CAPTURE;
        else if (w_tout) w_state_nxt = S_PUSH;
      end
      S_CAPTURE:     w_state_nxt = S_PUSH;
      S_PUSH: begin
        if (!FIFOB_full) begin
          FIFOB_wen   = 1'b1;
          w_state_nxt = S_BEAT_DONE;
        end
      end
      S_BEAT_DONE: begin
        if (w_last)             w_state_nxt = S_IDLE;
        else if (!r_wr)         w_state_nxt = r_abort ? S_IDLE : S_TRIG_R;
        else                    w_state_nxt = S_DFETCH;
      end
      S_DFETCH: begin
        if (!FIFOA_empty) begin
          FIFOA_ren   = 1'b1;
          w_state_nxt = S_DFETCH_WAIT;
        end
      end
      S_DFETCH_WAIT: w_state_nxt = S_DDECODE;
      // An aborted write burst loops through BEAT_DONE to drain every remaining data word.
      S_DDECODE:     w_state_nxt = r_abort ? S_BEAT_DONE : S_TRIG_W;
      default:       w_state_nxt = S_IDLE;
    endcase
  end

  // Command datapath, beat/address tracking, timeout counter and error count.
  // Read data is latched on the valid cycle so CAPTURE never depends on data being held.
  always_ff @(posedge CLK) begin
    if (rst) begin
      r_ch      <= '0;
      r_addr    <= '0;
      r_data    <= '0;
      r_rdata   <= '0;
      r_wr      <= 1'b0;
      r_inc     <= 1'b0;
      r_err     <= 1'b0;
      r_abort   <= 1'b0;
      r_len     <= '0;
      r_beat    <= '0;
      r_tcnt    <= '0;
      r_err_cnt <= '0;
    end else begin
      case (r_state)
        S_DECODE: begin
          r_ch    <= itf_sel_sync;
          r_data  <= FIFOA_OUT[DATA_W-1:0];
          r_addr  <= FIFOA_OUT[F_ADDR +: ADDR_W];
          r_wr    <= FIFOA_OUT[F_WR];
          r_inc   <= FIFOA_OUT[F_INC];
          r_len   <= FIFOA_OUT[F_LEN +: BURST_W];
          r_beat  <= '0;
          r_rdata <= '0;
          r_err   <= w_bad_ch;
          r_abort <= w_bad_ch;
          if (w_bad_ch) r_err_cnt <= sat_inc(r_err_cnt);
        end
        S_TRIG_W, S_TRIG_R: r_tcnt <= '0;
        S_WAIT_W, S_WAIT_R: begin
          if ((r_state == S_WAIT_W) ? w_fin : w_vld) begin
            if (r_state == S_WAIT_R) r_rdata <= w_rd;
          end else if (w_tout) begin
            r_err     <= 1'b1;
            r_abort   <= 1'b1;
            r_rdata   <= '0;
            r_err_cnt <= sat_inc(r_err_cnt);
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        S_BEAT_DONE: begin
          if (!r_wr && !r_abort && !w_last) begin
            r_beat <= r_beat + 1'b1;
            if (r_inc) r_addr <= r_addr + 1'b1;
          end
        end
        S_DDECODE: begin
          r_beat <= r_beat + 1'b1;
          if (!r_abort) begin
            r_data <= FIFOA_OUT[DATA_W-1:0];
            if (r_inc) r_addr <= r_addr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Response word assembly.
  always_comb begin
    FIFOB_IN                         = '0;
    FIFOB_IN[DATA_W-1:0]             = r_rdata;
    FIFOB_IN[DATA_W +: ADDR_W]       = r_addr;
    FIFOB_IN[RESP_CH_LSB +: SEL_W]   = r_ch;
    FIFOB_IN[RESP_ERR_BIT]           = r_err;
  end

  assign addr_byte = r_addr;
  assign data_byte = r_data;
  assign busy      = (r_state != S_IDLE);
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_fpga_tx_control_mc.sv
// Directed testbench for fpga_tx_control_mc with FIFO A model, FIFO B log and master responders.
module tb_fpga_tx_control_mc;

  localparam int N_ITF = 4;
  localparam int TOUT  = 8;
  localparam int SSYNC = 3;

  logic        CLK = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] FIFOA_OUT = '0;
  logic        FIFOA_ren, FIFOA_empty;
  logic [31:0] FIFOB_IN;
  logic        FIFOB_wen;
  logic        FIFOB_full = 1'b0;
  logic [3:0]  itf_sel = '0;
  logic [3:0]  itf_sel_sync;
  logic [7:0]  addr_byte, data_byte;
  logic [N_ITF-1:0] WriteByteStart, ReadByteStart;
  logic [N_ITF-1:0] itf_w_finish = '0;
  logic [N_ITF-1:0] itf_rd_valid = '0;
  logic [N_ITF*8-1:0] itf_rd_data = '0;
  logic        busy;
  logic [15:0] err_cnt;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  fpga_tx_control_mc #(
    .N_ITF(N_ITF), .ADDR_W(8), .DATA_W(8), .BURST_W(8),
    .TIMEOUT_CYC(TOUT), .SEL_SYNC(SSYNC)
  ) dut (
    .CLK(CLK), .rst(rst),
    .FIFOA_OUT(FIFOA_OUT), .FIFOA_ren(FIFOA_ren), .FIFOA_empty(FIFOA_empty),
    .FIFOB_IN(FIFOB_IN), .FIFOB_wen(FIFOB_wen), .FIFOB_full(FIFOB_full),
    .itf_sel(itf_sel), .itf_sel_sync(itf_sel_sync),
    .addr_byte(addr_byte), .data_byte(data_byte),
    .WriteByteStart(WriteByteStart), .ReadByteStart(ReadByteStart),
    .itf_w_finish(itf_w_finish), .itf_rd_valid(itf_rd_valid), .itf_rd_data(itf_rd_data),
    .busy(busy), .err_cnt(err_cnt)
  );

  // FIFO A model: data appears the edge after ren and holds until the next pop.
  logic [31:0] fa_mem [0:63];
  int unsigned wp = 0;
  int unsigned rp = 0;
  assign FIFOA_empty = (rp == wp);
  always @(posedge CLK) begin
    if (FIFOA_ren) begin
      FIFOA_OUT <= fa_mem[rp % 64];
      rp <= rp + 1;
    end
  end

  // Strobe / response monitor.
  int ws_cnt = 0, rs_cnt = 0, wen_cnt = 0;
  logic [N_ITF-1:0] ws_last = '0;
  logic [7:0]  ws_addr = '0, ws_data = '0;
  logic [31:0] resp_log [0:63];
  always @(posedge CLK) begin
    if (|WriteByteStart) begin
      ws_cnt++;
      ws_last <= WriteByteStart;
      ws_addr <= addr_byte;
      ws_data <= data_byte;
    end
    if (|ReadByteStart) rs_cnt++;
    if (FIFOB_wen) begin
      resp_log[wen_cnt % 64] <= FIFOB_IN;
      wen_cnt++;
    end
  end

  // Interface master responders: finish/valid 3 cycles after the start pulse.
  bit         wr_en = 1'b1;
  bit         rd_en = 1'b1;
  logic [7:0] rd_xor = '0;
  int wcnt [N_ITF];
  int rcnt [N_ITF];
  initial for (int k = 0; k < N_ITF; k++) begin wcnt[k] = 0; rcnt[k] = 0; end
  always @(posedge CLK) begin
    logic [N_ITF-1:0] fin_n, vld_n;
    fin_n = '0;
    vld_n = '0;
    for (int k = 0; k < N_ITF; k++) begin
      if (wcnt[k] != 0) begin
        wcnt[k]--;
        if (wcnt[k] == 0) fin_n[k] = 1'b1;
      end else if (WriteByteStart[k] && wr_en) begin
        wcnt[k] = 2;
      end
      if (rcnt[k] != 0) begin
        rcnt[k]--;
        if (rcnt[k] == 0) begin
          vld_n[k] = 1'b1;
          itf_rd_data[k*8 +: 8] <= addr_byte ^ rd_xor;
        end
      end else if (ReadByteStart[k] && rd_en) begin
        rcnt[k] = 2;
      end
    end
    itf_w_finish <= fin_n;
    itf_rd_valid <= vld_n;
  end

  task automatic push(input logic [31:0] w);
    fa_mem[wp % 64] = w;
    wp = wp + 1;
  endtask

  task automatic set_sel(input logic [3:0] v);
    itf_sel = v;
    repeat (SSYNC + 2) @(posedge CLK);
    #1;
  endtask

  task automatic wait_idle(input int max_cyc, output bit ok);
    ok = 1'b0;
    repeat (2) @(posedge CLK);
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge CLK);
      #1;
      if (!busy && rp == wp) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if ({busy, FIFOA_ren, FIFOB_wen} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=000", {busy, FIFOA_ren, FIFOB_wen});
    end
    checks++;
    if ({WriteByteStart, ReadByteStart, addr_byte, data_byte, FIFOB_IN, err_cnt} !== '0) begin
      errors++; $display("FAIL reset_data got ws=%b rs=%b addr=%h data=%h fb=%h err=%h exp all zero",
                         WriteByteStart, ReadByteStart, addr_byte, data_byte, FIFOB_IN, err_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_write();
    int ws0, wen0;
    bit ok;
    set_sel(4'd1);
    checks++;
    if (itf_sel_sync !== 4'd1) begin
      errors++; $display("FAIL sel_sync got=%0d exp=1", itf_sel_sync);
    end
    wr_en = 1'b1;
    ws0 = ws_cnt; wen0 = wen_cnt;
    push(32'h0001_5AA5);
    wait_idle(100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_write_done got=busy exp=idle"); end
    checks++;
    if (ws_cnt - ws0 !== 1 || ws_last !== 4'b0010) begin
      errors++; $display("FAIL single_write_start got cnt=%0d vec=%b exp cnt=1 vec=0010", ws_cnt - ws0, ws_last);
    end
    checks++;
    if (ws_addr !== 8'h5A || ws_data !== 8'hA5) begin
      errors++; $display("FAIL single_write_bytes got addr=%h data=%h exp addr=5a data=a5", ws_addr, ws_data);
    end
    checks++;
    if (wen_cnt !== wen0) begin
      errors++; $display("FAIL single_write_nowen got=%0d exp=%0d", wen_cnt, wen0);
    end
  endtask

  task automatic test_single_read();
    int rs0, wen0;
    bit ok;
    set_sel(4'd2);
    rd_xor = 8'h4B;
    rs0 = rs_cnt; wen0 = wen_cnt;
    push(32'h0000_3C00);
    wait_idle(100, ok);
    checks++;
    if (!ok || rs_cnt - rs0 !== 1 || wen_cnt - wen0 !== 1) begin
      errors++; $display("FAIL single_read_pulses got ok=%0d rs=%0d wen=%0d exp ok=1 rs=1 wen=1",
                         ok, rs_cnt - rs0, wen_cnt - wen0);
    end
    checks++;
    if (resp_log[wen0 % 64] !== 32'h0200_3C77) begin
      errors++; $display("FAIL single_read_resp got=%h exp=02003c77", resp_log[wen0 % 64]);
    end
  endtask

  task automatic test_read_burst();
    logic [31:0] exp_r [4];
    int wen0;
    bit ok;
    exp_r[0] = 32'h0000_FEFE; exp_r[1] = 32'h0000_FFFF;
    exp_r[2] = 32'h0000_0000; exp_r[3] = 32'h0000_0101;
    set_sel(4'd0);
    rd_xor = 8'h00;
    wen0 = wen_cnt;
    push(32'h000E_FE00);
    wait_idle(200, ok);
    checks++;
    if (!ok || wen_cnt - wen0 !== 4) begin
      errors++; $display("FAIL burst_count got ok=%0d n=%0d exp ok=1 n=4", ok, wen_cnt - wen0);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (resp_log[(wen0 + i) % 64] !== exp_r[i]) begin
        errors++; $display("FAIL burst_resp%0d got=%h exp=%h", i, resp_log[(wen0 + i) % 64], exp_r[i]);
      end
    end
  endtask

  task automatic test_write_timeout();
    int ws0, wen0;
    bit ok;
    set_sel(4'd3);
    wr_en = 1'b0;
    ws0 = ws_cnt; wen0 = wen_cnt;
    push(32'h000B_4011);
    push(32'h0000_0022);
    push(32'h0000_0033);
    wait_idle(200, ok);
    checks++;
    if (!ok || rp !== wp) begin
      errors++; $display("FAIL timeout_drain got ok=%0d left=%0d exp ok=1 left=0", ok, wp - rp);
    end
    checks++;
    if (ws_cnt - ws0 !== 1 || wen_cnt - wen0 !== 1) begin
      errors++; $display("FAIL timeout_pulses got ws=%0d wen=%0d exp ws=1 wen=1", ws_cnt - ws0, wen_cnt - wen0);
    end
    checks++;
    if (resp_log[wen0 % 64] !== 32'h8300_4000) begin
      errors++; $display("FAIL timeout_resp got=%h exp=83004000", resp_log[wen0 % 64]);
    end
    checks++;
    if (err_cnt !== 16'd1) begin
      errors++; $display("FAIL timeout_errcnt got=%0d exp=1", err_cnt);
    end
    wr_en = 1'b1;
    ws0 = ws_cnt; wen0 = wen_cnt;
    push(32'h0001_7788);
    wait_idle(100, ok);
    checks++;
    if (!ok || ws_cnt - ws0 !== 1 || ws_addr !== 8'h77 || ws_data !== 8'h88 || wen_cnt !== wen0) begin
      errors++; $display("FAIL after_timeout_write got ok=%0d ws=%0d addr=%h data=%h wen=%0d exp 1 1 77 88 0",
                         ok, ws_cnt - ws0, ws_addr, ws_data, wen_cnt - wen0);
    end
  endtask

  task automatic test_full_stall();
    int wen0;
    bit ok;
    set_sel(4'd2);
    rd_xor = 8'h00;
    FIFOB_full = 1'b1;
    wen0 = wen_cnt;
    push(32'h0000_5500);
    repeat (20) @(posedge CLK);
    #1;
    checks++;
    if (wen_cnt !== wen0 || busy !== 1'b1) begin
      errors++; $display("FAIL stall_hold got wen=%0d busy=%b exp wen=0 busy=1", wen_cnt - wen0, busy);
    end
    FIFOB_full = 1'b0;
    wait_idle(100, ok);
    checks++;
    if (!ok || wen_cnt - wen0 !== 1 || resp_log[wen0 % 64] !== 32'h0200_5555) begin
      errors++; $display("FAIL stall_release got ok=%0d wen=%0d resp=%h exp ok=1 wen=1 resp=02005555",
                         ok, wen_cnt - wen0, resp_log[wen0 % 64]);
    end
    checks++;
    if (err_cnt !== 16'd1) begin
      errors++; $display("FAIL stall_errcnt got=%0d exp=1", err_cnt);
    end
  endtask

  task automatic test_reset_midop();
    int wen0, rs0;
    bit ok;
    set_sel(4'd1);
    rd_en = 1'b0;
    wen0 = wen_cnt;
    push(32'h0000_1200);
    repeat (7) @(posedge CLK);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL midop_busy got=%b exp=1", busy);
    end
    rst = 1'b1;
    @(posedge CLK);
    #1;
    checks++;
    if ({busy, FIFOA_ren, FIFOB_wen, WriteByteStart, ReadByteStart, addr_byte, data_byte,
         FIFOB_IN, err_cnt, itf_sel_sync} !== '0) begin
      errors++; $display("FAIL midop_reset got busy=%b addr=%h fb=%h err=%0d sync=%0d exp all zero",
                         busy, addr_byte, FIFOB_IN, err_cnt, itf_sel_sync);
    end
    rst = 1'b0;
    rd_en = 1'b1;
    set_sel(4'd1);
    rs0 = rs_cnt;
    push(32'h0000_1200);
    wait_idle(100, ok);
    checks++;
    if (!ok || rs_cnt - rs0 !== 1 || wen_cnt - wen0 !== 1 || resp_log[wen0 % 64] !== 32'h0100_1212) begin
      errors++; $display("FAIL midop_recover got ok=%0d rs=%0d wen=%0d resp=%h exp ok=1 rs=1 wen=1 resp=01001212",
                         ok, rs_cnt - rs0, wen_cnt - wen0, resp_log[wen0 % 64]);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_read_burst();
    test_write_timeout();
    test_full_stall();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
